// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared QSPI lane-mode and target FSM types
package qspi_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10
  } qspi_mode_t;

  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    TGT_IDLE,
    TGT_SHIFT,
    TGT_DONE
  } tgt_state_t;

  function automatic logic [2:0] bits_per_edge(qspi_mode_t m);
    case (m)
      MODE_DUAL: return 3'd2;
      MODE_QUAD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// rtl/qspi_sync_edge.sv - N-stage synchronizer with registered edge detect
module qspi_sync_edge #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[STAGES-1];
    end
  end

  assign q    = stage[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/qspi_target.sv
// rtl/qspi_target.sv - single-word QSPI target, SPI mode 0, single/dual/quad lanes
module qspi_target
  import qspi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  nrst,
  input  logic                  cs_n,
  input  logic                  sclk,
  inout  wire  [3:0]            IO,
  input  logic [1:0]            sel_mode,
  input  logic                  operation,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_taken,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  function automatic logic [BW-1:0] beats_for(qspi_mode_t m);
    case (m)
      MODE_DUAL: return BW'(DATA_WIDTH / 2);
      MODE_QUAD: return BW'(DATA_WIDTH / 4);
      default:   return BW'(DATA_WIDTH);
    endcase
  endfunction

  logic [1:0] ctl_level_unused, ctl_rise, ctl_fall;
  logic [3:0] io_q, io_rise_unused, io_fall_unused;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

  // bit 0 = cs_n (resets high), bit 1 = sclk (resets low): no false edge out of reset
  qspi_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES), .RESET_VAL(2'b01)) u_ctl_sync (
    .sys_clk (sys_clk),
    .nrst    (nrst),
    .din     ({sclk, cs_n}),
    .q       (ctl_level_unused),
    .rise    (ctl_rise),
    .fall    (ctl_fall)
  );

  qspi_sync_edge #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VAL(4'b0000)) u_io_sync (
    .sys_clk (sys_clk),
    .nrst    (nrst),
    .din     (IO),
    .q       (io_q),
    .rise    (io_rise_unused),
    .fall    (io_fall_unused)
  );

  assign cs_fall   = ctl_fall[0];
  assign cs_rise   = ctl_rise[0];
  assign sclk_rise = ctl_rise[1];
  assign sclk_fall = ctl_fall[1];

  tgt_state_t            state, state_n;
  qspi_mode_t            mode, mode_n;
  logic                  is_write, is_write_n;
  logic [BW-1:0]         beat_cnt, beat_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n, shift_in, rx_data_n;
  logic                  rx_valid_n, tx_taken_n, frame_err_n, busy_n;
  logic                  drive_en, drive_n;
  logic [3:0]            lane_out, lane_mask, io_out, io_oe;

  // Lane 0 carries the most significant bit of each group
  always_comb begin
    shift_in = {shift_reg[DATA_WIDTH-2:0], io_q[0]};
    lane_out = '0;
    case (mode)
      MODE_DUAL: begin
        shift_in = {shift_reg[DATA_WIDTH-3:0], io_q[0], io_q[1]};
        lane_out = {2'b00, shift_reg[DATA_WIDTH-2], shift_reg[DATA_WIDTH-1]};
      end
      MODE_QUAD: begin
        shift_in = {shift_reg[DATA_WIDTH-5:0], io_q[0], io_q[1], io_q[2], io_q[3]};
        lane_out = {shift_reg[DATA_WIDTH-4], shift_reg[DATA_WIDTH-3],
                    shift_reg[DATA_WIDTH-2], shift_reg[DATA_WIDTH-1]};
      end
      default: lane_out[1] = shift_reg[DATA_WIDTH-1];
    endcase
    lane_mask = (mode == MODE_SINGLE) ? 4'b0010
                                      : 4'((5'd1 << bits_per_edge(mode)) - 5'd1);
  end

  always_comb begin
    state_n     = state;
    mode_n      = mode;
    is_write_n  = is_write;
    beat_n      = beat_cnt;
    shift_n     = shift_reg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    tx_taken_n  = 1'b0;
    frame_err_n = 1'b0;
    busy_n      = busy;
    drive_n     = drive_en;
    case (state)
      TGT_IDLE: begin
        if (cs_fall) begin
          is_write_n = operation;
          if (sel_mode == MODE_ILLEGAL) begin
            frame_err_n = 1'b1;
            state_n     = TGT_DONE;
          end else begin
            mode_n  = qspi_mode_t'(sel_mode);
            beat_n  = beats_for(qspi_mode_t'(sel_mode));
            busy_n  = 1'b1;
            state_n = TGT_SHIFT;
            if (!operation) begin
              shift_n    = tx_data;
              tx_taken_n = 1'b1;
              drive_n    = 1'b1;
            end
          end
        end
      end
      TGT_SHIFT: begin
        if (cs_rise) begin
          frame_err_n = 1'b1;
          busy_n      = 1'b0;
          drive_n     = 1'b0;
          state_n     = TGT_IDLE;
        end else if (beat_cnt == '0) begin
          if (is_write) begin
            rx_data_n  = shift_reg;
            rx_valid_n = 1'b1;
          end
          state_n = TGT_DONE;
        end else if (sclk_rise) begin
          beat_n = beat_cnt - 1'b1;
          if (is_write) shift_n = shift_in;
        end else if (sclk_fall && !is_write) begin
          shift_n = shift_reg << bits_per_edge(mode);
        end
      end
      TGT_DONE: begin
        if (cs_rise) begin
          busy_n  = 1'b0;
          drive_n = 1'b0;
          state_n = TGT_IDLE;
        end
      end
      default: state_n = TGT_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      state     <= TGT_IDLE;
      mode      <= MODE_SINGLE;
      is_write  <= 1'b0;
      beat_cnt  <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_taken  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      drive_en  <= 1'b0;
      io_out    <= '0;
      io_oe     <= '0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      is_write  <= is_write_n;
      beat_cnt  <= beat_n;
      shift_reg <= shift_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_taken  <= tx_taken_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
      drive_en  <= drive_n;
      io_out    <= lane_out;
      io_oe     <= drive_en ? lane_mask : 4'b0000;
    end
  end

  assign IO[0] = io_oe[0] ? io_out[0] : 1'bz;
  assign IO[1] = io_oe[1] ? io_out[1] : 1'bz;
  assign IO[2] = io_oe[2] ? io_out[2] : 1'bz;
  assign IO[3] = io_oe[3] ? io_out[3] : 1'bz;

endmodule

// File: doc/qspi_target.md
# qspi_target

Single-word QSPI target (responder) that sits on the far side of the QSPI master's `chip_select`/`sclk`/`IO[3:0]` bus, SPI mode 0. All bus inputs are oversampled in the `sys_clk` domain. The block shifts in one `DATA_WIDTH` word per chip-select frame when the master writes, and shifts out a preloaded word when the master reads. It runs in single, dual or quad mode. Intended as the target-side model and the FPGA-side peripheral for QSPI master loopback tests.

## Interface
- `DATA_WIDTH`, 8: word length; must be a multiple of 4.
- `SYNC_STAGES`, 2: synchronizer depth applied to `cs_n`, `sclk` and `IO`.

- `sys_clk` input 1: block clock. Must run at ≥ 8× the `sclk` frequency; master `CLOCK_DIVIDER` ≥ 4.
- `nrst` input 1: reset, asynchronous, active-low. Clock is `sys_clk`.
- `cs_n` input 1: chip select from the master, active-low.
- `sclk` input 1: serial clock from the master. Idles low (CPOL = 0).
- `IO` inout 4: bidirectional data lanes.
- `sel_mode` input 2: lane mode. 00 = single, 01 = dual, 10 = quad, 11 = illegal. Sampled at the `cs_n` fall.
- `operation` input 1: master direction. 0 = master reads (target drives), 1 = master writes. Sampled at the `cs_n` fall.
- `tx_data` input DATA_WIDTH: word returned on a master read. Sampled at the `cs_n` fall.
- `rx_data` output DATA_WIDTH: last complete word written by the master. Held until the next complete write.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `tx_taken` output 1: one-cycle pulse when `tx_data` is captured.
- `frame_err` output 1: one-cycle pulse on an aborted frame or an illegal mode.
- `busy` output 1: high from the frame start to the frame end.

## Operation
- Lane mapping, MSB first. Bits per edge (BPE) is 1, 2 or 4.
  - Single: master-write data arrives on IO0; target read data is driven on IO1.
  - Dual: IO0 carries bit n, IO1 carries bit n-1.
  - Quad: IO0..IO3 carry bits n, n-1, n-2, n-3.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on a synchronized `cs_n` fall:
  - Latch `sel_mode` and `operation`.
  - If `sel_mode` = 11: pulse `frame_err`, go to DONE, never drive `IO`.
  - Otherwise set `busy`, set `beat_cnt` = DATA_WIDTH/BPE, and enter SHIFT.
  - If reading: load the shift register from `tx_data`, pulse `tx_taken`, enable the lanes for the mode, and drive the top BPE bits immediately.
- SHIFT, write direction: on each synchronized `sclk` rise, shift the synchronized `IO` lanes in and decrement `beat_cnt`. When `beat_cnt` reaches 0: `rx_data` ← shift register, pulse `rx_valid`, go to DONE.
- SHIFT, read direction: on each `sclk` rise, decrement `beat_cnt`. On each `sclk` fall with `beat_cnt` ≠ 0, present the next BPE bits. When `beat_cnt` reaches 0, go to DONE. Lanes stay driven until `cs_n` rises.
- DONE: ignore all further `sclk` edges. On the `cs_n` rise: release `IO` to Z, clear `busy`, go to IDLE.
- `cs_n` rise while in SHIFT: abort. Pulse `frame_err`, leave `rx_data` unchanged, no `rx_valid`, release `IO`, return to IDLE.
- `sclk` edges while `cs_n` is high are ignored.
- `cs_n` fall and `sclk` rise seen in the same cycle: the frame start is processed first; that edge is not counted.
- Reset (async, including mid-frame):
  - `rx_data` = 0.
  - `rx_valid`, `tx_taken`, `frame_err`, `busy` = 0.
  - `IO` enables = 0 (all lanes Z).
  - State = IDLE.
  - Synchronizer flops are cleared to `cs_n` = 1 and `sclk` = 0, so no spurious edge is seen after reset.

## Timing
- Input path: `SYNC_STAGES` flops, then one edge-detect flop. `IO` passes through the same-depth synchronizer as `sclk`, so sampled data stays aligned with its edge.
- `sclk` pin edge to internal action: 3 `sys_clk` cycles. New `IO` drive appears 1 cycle later (registered output), i.e. 4 cycles after the `sclk` fall.
- This must complete within half an `sclk` period, which is why master `CLOCK_DIVIDER` ≥ 4.
- `cs_n` fall to first read bits valid on `IO`: 4 cycles.
- Last `sclk` rise to the `rx_valid` pulse: 4 cycles.

## Structure
- Shared package `qspi_pkg`:
  - `qspi_mode_t` enum: MODE_SINGLE = 2'b00, MODE_DUAL = 2'b01, MODE_QUAD = 2'b10.
  - Target FSM state enum.
  - Function `bits_per_edge(qspi_mode_t)`.
  - The master moves onto the same mode enum.
- Sub-module `qspi_sync_edge`: parameterized-width N-stage synchronizer with rise/fall pulse outputs. Instantiated for `cs_n`/`sclk`; a data-only instance is used for `IO`.

## Test plan
- Single-mode write of 8'hA5 from the QSPI master (`CLOCK_DIVIDER` = 4) → `rx_data` = 8'hA5, exactly one `rx_valid`, `IO` never driven by the target.
- Quad-mode read with `tx_data` = 8'h3C → master `rd_data` = 8'h3C, `tx_taken` once at the `cs_n` fall, `IO` = Z after `cs_n` rises.
- Dual-mode write 8'h96, then dual-mode read with `tx_data` = 8'h5A, back to back → `rx_data` = 8'h96, master reads 8'h5A.
- `cs_n` deasserted after 5 single-mode `sclk` rises → `frame_err` pulse, `rx_data` keeps its prior value, `busy` = 0.
- `sel_mode` = 11 frame → `frame_err` pulse, no `IO` drive, no `rx_valid`.
- `nrst` asserted mid-quad-read → `IO` = Z and all outputs 0 asynchronously. The next single write of 8'h01 is received correctly.
